framer_ctrl: RTL and testbench



---
 rtl/framer_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_framer_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/framer_ctrl.sv
// framer_ctrl: transmit framer sequencing controller.
// Accepts one message at a time, stamps it with a message counter and timer,
// fetches an authentication tag from the MAC engine (with timeout), loads the
// framer override fields, then offers the finished frame downstream.
// Field values of zero mean pass-through to the framer, so every value driven
// in LOAD/OUT is kept non-zero.

module framer_ctrl #(
   parameter int TICK_DIV    = 16,
   parameter int MAC_TIMEOUT = 64
) (
   input  logic       clk,
   input  logic       resetN,
   input  logic       msg_valid,
   output logic       msg_ready,
   output logic       mac_start,
   input  logic       mac_done,
   input  logic [7:0] mac_tag,
   output logic [7:0] ctl_msg_counter,
   output logic [7:0] ctl_timer,
   output logic [7:0] ctl_auth_tag,
   output logic [1:0] ctl_state_bits,
   output logic       frame_valid,
   input  logic       frame_ready,
   output logic       busy
);

   localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
   localparam logic [9:0]    WAIT_LAST = 10'(MAC_TIMEOUT - 1);

   localparam logic [1:0] ST_MAC_OK   = 2'b01;
   localparam logic [1:0] ST_TIMEOUT  = 2'b10;
   localparam logic [1:0] ST_CNT_WRAP = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_MAC_REQ  = 3'd1,
      S_MAC_WAIT = 3'd2,
      S_LOAD     = 3'd3,
      S_OUT      = 3'd4
   } state_t;

   state_t state_r;
   state_t state_s;

   logic [TW-1:0] tick_r;
   logic [7:0]    timer_r;
   logic [7:0]    msg_cnt_r;
   logic [7:0]    cur_cnt_r;
   logic [7:0]    cur_time_r;
   logic [7:0]    tag_r;
   logic [1:0]    status_r;
   logic [9:0]    wait_r;

   // Counter step that never produces zero: FF wraps to 01.
   function automatic logic [7:0] inc_nz(input logic [7:0] v);
      inc_nz = (v == 8'hFF) ? 8'h01 : (v + 8'h01);
   endfunction

   // Free-running timestamp: tick divider plus non-zero 8-bit timer.
   always_ff @(posedge clk) begin
      if (!resetN) begin
         tick_r  <= {TW{1'b0}};
         timer_r <= 8'h01;
      end else if (tick_r == TICK_LAST) begin
         tick_r  <= {TW{1'b0}};
         timer_r <= inc_nz(timer_r);
      end else begin
         tick_r  <= tick_r + {{(TW-1){1'b0}}, 1'b1};
      end
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (!resetN) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Per-message datapath: captured counter/time, tag, status, wait counter.
   always_ff @(posedge clk) begin
      if (!resetN) begin
         msg_cnt_r  <= 8'h01;
         cur_cnt_r  <= 8'h00;
         cur_time_r <= 8'h00;
         tag_r      <= 8'h00;
         status_r   <= 2'b00;
         wait_r     <= 10'd0;
      end else begin
         case (state_r)
            S_IDLE: begin
               if (msg_valid) begin
                  cur_cnt_r  <= msg_cnt_r;
                  cur_time_r <= timer_r;
               end
            end
            S_MAC_REQ: begin
               wait_r <= 10'd0;
            end
            S_MAC_WAIT: begin
               // A done coinciding with the last wait cycle still wins.
               if (mac_done) begin
                  tag_r    <= (mac_tag == 8'h00) ? 8'hFF : mac_tag;
                  status_r <= ST_MAC_OK;
               end else if (wait_r == WAIT_LAST) begin
                  tag_r    <= 8'hFF;
                  status_r <= ST_TIMEOUT;
               end else begin
                  wait_r   <= wait_r + 10'd1;
               end
            end
            S_OUT: begin
               if (frame_ready) begin
                  msg_cnt_r <= inc_nz(msg_cnt_r);
               end
            end
            default: begin
               wait_r <= wait_r;
            end
         endcase
      end
   end

   // Next-state decode.
   always_comb begin
      state_s = state_r;
      case (state_r)
         S_IDLE: begin
            if (msg_valid) state_s = S_MAC_REQ;
            else           state_s = S_IDLE;
         end
         S_MAC_REQ: begin
            state_s = S_MAC_WAIT;
         end
         S_MAC_WAIT: begin
            if (mac_done || (wait_r == WAIT_LAST)) state_s = S_LOAD;
            else                                    state_s = S_MAC_WAIT;
         end
         S_LOAD: begin
            state_s = S_OUT;
         end
         S_OUT: begin
            if (frame_ready) state_s = S_IDLE;
            else             state_s = S_OUT;
         end
         default: begin
            state_s = S_IDLE;
         end
      endcase
   end

   // Output decode from the registered state and captured fields.
   always_comb begin
      msg_ready       = 1'b0;
      mac_start       = 1'b0;
      ctl_msg_counter = 8'h00;
      ctl_timer       = 8'h00;
      ctl_auth_tag    = 8'h00;
      ctl_state_bits  = 2'b00;
      frame_valid     = 1'b0;
      busy            = (state_r != S_IDLE);
      case (state_r)
         S_IDLE: begin
            // No accept while reset is being applied.
            msg_ready = msg_valid & resetN;
         end
         S_MAC_REQ: begin
            mac_start = 1'b1;
         end
         S_LOAD, S_OUT: begin
            ctl_msg_counter = cur_cnt_r;
            ctl_timer       = cur_time_r;
            ctl_auth_tag    = tag_r;
            if ((cur_cnt_r == 8'hFF) && (status_r == ST_MAC_OK)) begin
               ctl_state_bits = ST_CNT_WRAP;
            end else begin
               ctl_state_bits = status_r;
            end
            frame_valid = (state_r == S_OUT);
         end
         default: begin
            busy = 1'b1;
         end
      endcase
   end

endmodule

// File: tb/tb_framer_ctrl.sv
// Directed self-checking bench for framer_ctrl (TICK_DIV=2, MAC_TIMEOUT=64).
// Inputs change on the falling edge; outputs are sampled 1 ns later.

module tb_framer_ctrl;

   localparam int TICK_DIV    = 2;
   localparam int MAC_TIMEOUT = 64;

   logic       clk = 1'b0;
   logic       resetN = 1'b0;
   logic       msg_valid = 1'b0;
   logic       mac_done = 1'b0;
   logic [7:0] mac_tag = 8'h00;
   logic       frame_ready = 1'b0;
   logic       msg_ready;
   logic       mac_start;
   logic [7:0] ctl_msg_counter;
   logic [7:0] ctl_timer;
   logic [7:0] ctl_auth_tag;
   logic [1:0] ctl_state_bits;
   logic       frame_valid;
   logic       busy;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference timestamp and expected message counter.
   int         m_tick;
   logic [7:0] m_timer;
   logic [7:0] m_cnt;

   framer_ctrl #(.TICK_DIV(TICK_DIV), .MAC_TIMEOUT(MAC_TIMEOUT)) dut (
      .clk(clk), .resetN(resetN), .msg_valid(msg_valid), .msg_ready(msg_ready),
      .mac_start(mac_start), .mac_done(mac_done), .mac_tag(mac_tag),
      .ctl_msg_counter(ctl_msg_counter), .ctl_timer(ctl_timer),
      .ctl_auth_tag(ctl_auth_tag), .ctl_state_bits(ctl_state_bits),
      .frame_valid(frame_valid), .frame_ready(frame_ready), .busy(busy)
   );

   always #5 clk = ~clk;

   // Reference timer: divider wraps every TICK_DIV cycles, timer skips zero.
   always @(posedge clk) begin
      if (!resetN) begin
         m_tick  <= 0;
         m_timer <= 8'h01;
      end else if (m_tick == TICK_DIV - 1) begin
         m_tick  <= 0;
         m_timer <= (m_timer == 8'hFF) ? 8'h01 : m_timer + 8'h01;
      end else begin
         m_tick  <= m_tick + 1;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_zero(input string where);
      check({where, ".msg_ready"}, 32'(msg_ready), 32'd0);
      check({where, ".mac_start"}, 32'(mac_start), 32'd0);
      check({where, ".ctl_cnt"}, 32'(ctl_msg_counter), 32'd0);
      check({where, ".ctl_timer"}, 32'(ctl_timer), 32'd0);
      check({where, ".ctl_tag"}, 32'(ctl_auth_tag), 32'd0);
      check({where, ".ctl_bits"}, 32'(ctl_state_bits), 32'd0);
      check({where, ".frame_valid"}, 32'(frame_valid), 32'd0);
      check({where, ".busy"}, 32'(busy), 32'd0);
   endtask

   task automatic check_fields(input string where, input logic [7:0] c, input logic [7:0] t,
                               input logic [7:0] a, input logic [1:0] b);
      check({where, ".ctl_cnt"}, 32'(ctl_msg_counter), 32'(c));
      check({where, ".ctl_timer"}, 32'(ctl_timer), 32'(t));
      check({where, ".ctl_tag"}, 32'(ctl_auth_tag), 32'(a));
      check({where, ".ctl_bits"}, 32'(ctl_state_bits), 32'(b));
   endtask

   // Cycle 0: accept with msg_ready; cycle 1: mac_start pulse.
   task automatic accept(output logic [7:0] t_acc);
      @(negedge clk);
      msg_valid   = 1'b1;
      frame_ready = 1'b0;
      #1;
      check("accept.msg_ready", 32'(msg_ready), 32'd1);
      check("accept.busy", 32'(busy), 32'd0);
      check("accept.frame_valid", 32'(frame_valid), 32'd0);
      t_acc = m_timer;
      @(negedge clk);
      msg_valid = 1'b0;
      #1;
      check("req.mac_start", 32'(mac_start), 32'd1);
      check("req.msg_ready", 32'(msg_ready), 32'd0);
      check("req.busy", 32'(busy), 32'd1);
   endtask

   // Pulse mac_done in MAC_WAIT cycle dd (dd<0: never); return when LOAD is seen.
   task automatic wait_load(input int dd, input logic [7:0] tg, input int exp_k);
      int load_at;
      load_at = -1;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         mac_done = (k == dd);
         mac_tag  = tg;
         #1;
         if (k == 0) check("wait.mac_start_once", 32'(mac_start), 32'd0);
         if (ctl_msg_counter != 8'h00) begin
            load_at = k;
            break;
         end
      end
      mac_done = 1'b0;
      check("wait.load_cycle", 32'(load_at), 32'(exp_k));
      check("load.frame_valid", 32'(frame_valid), 32'd0);
   endtask

   // OUT phase: stall cycles with ready low (and a rejected msg_valid), then handshake.
   task automatic finish_out(input int stall, input logic [7:0] c, input logic [7:0] t,
                             input logic [7:0] a, input logic [1:0] b);
      for (int s = 0; s < stall; s++) begin
         @(negedge clk);
         frame_ready = 1'b0;
         msg_valid   = 1'b1;
         #1;
         check("stall.frame_valid", 32'(frame_valid), 32'd1);
         check("stall.msg_ready", 32'(msg_ready), 32'd0);
         check_fields("stall", c, t, a, b);
      end
      @(negedge clk);
      frame_ready = 1'b1;
      msg_valid   = 1'b0;
      #1;
      check("out.frame_valid", 32'(frame_valid), 32'd1);
      check_fields("out", c, t, a, b);
   endtask

   task automatic frame(input int dd, input logic [7:0] tg, input int stall,
                        input logic [7:0] exp_tag, input logic [1:0] exp_bits);
      logic [7:0] t;
      int exp_k;
      accept(t);
      exp_k = (dd >= 0 && dd < MAC_TIMEOUT) ? dd + 1 : MAC_TIMEOUT;
      wait_load(dd, tg, exp_k);
      check_fields("load", m_cnt, t, exp_tag, exp_bits);
      finish_out(stall, m_cnt, t, exp_tag, exp_bits);
      m_cnt = (m_cnt == 8'hFF) ? 8'h01 : m_cnt + 8'h01;
   endtask

   task automatic do_reset();
      @(negedge clk);
      resetN    = 1'b0;
      msg_valid = 1'b0;
      mac_done  = 1'b0;
      frame_ready = 1'b0;
      @(negedge clk);
      #1;
      check_zero("reset");
      resetN = 1'b1;
      m_cnt  = 8'h01;
   endtask

   initial begin
      logic [7:0] t;
      logic [7:0] tg;
      bit found;

      // Reset state.
      repeat (2) @(negedge clk);
      do_reset();

      // Basic frame: 1-cycle MAC, tag 5A, immediate ready; next accept is cycle 5.
      frame(0, 8'h5A, 0, 8'h5A, 2'b01);
      // MAC never answers: timeout tag FF, status 10, counter still advances.
      frame(-1, 8'h77, 0, 8'hFF, 2'b10);
      // Zero tag from MAC is replaced by FF.
      frame(1, 8'h00, 0, 8'hFF, 2'b01);
      // Done on the last wait cycle wins over timeout.
      frame(MAC_TIMEOUT - 1, 8'h3C, 0, 8'h3C, 2'b01);
      // Downstream stalls 20 cycles in OUT.
      frame(2, 8'h81, 20, 8'h81, 2'b01);

      // Late mac_done while idle must not affect the next message.
      @(negedge clk);
      mac_done = 1'b1;
      mac_tag  = 8'hEE;
      #1;
      check("late.busy", 32'(busy), 32'd0);
      check("late.mac_start", 32'(mac_start), 32'd0);
      mac_done = 1'b0;
      frame(1, 8'h12, 0, 8'h12, 2'b01);

      // Reset during MAC_WAIT aborts; no mac_start/frame_valid afterwards.
      accept(t);
      repeat (3) @(negedge clk);
      resetN = 1'b0;
      @(negedge clk);
      #1;
      check_zero("rst_wait");
      resetN = 1'b1;
      m_cnt  = 8'h01;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         mac_done = (i == 2);
         mac_tag  = 8'h99;
         #1;
         check("rst_wait.after_mac_start", 32'(mac_start), 32'd0);
         check("rst_wait.after_frame_valid", 32'(frame_valid), 32'd0);
      end
      mac_done = 1'b0;
      frame(0, 8'h44, 0, 8'h44, 2'b01);
      frame(0, 8'h45, 0, 8'h45, 2'b01);

      // Reset during OUT aborts the frame; counter restarts at 01.
      accept(t);
      wait_load(0, 8'h66, 1);
      @(negedge clk);
      #1;
      check("rst_out.frame_valid", 32'(frame_valid), 32'd1);
      resetN = 1'b0;
      @(negedge clk);
      #1;
      check_zero("rst_out");
      resetN = 1'b1;
      m_cnt  = 8'h01;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         #1;
         check("rst_out.after_frame_valid", 32'(frame_valid), 32'd0);
      end
      frame(0, 8'h21, 0, 8'h21, 2'b01);

      // Timer wrap: accept on the last cycle of FF, then 5 cycles later expect 03.
      found = 1'b0;
      for (int i = 0; i < 1200; i++) begin
         @(negedge clk);
         #1;
         if (m_timer == 8'hFF && m_tick == 0) begin
            found = 1'b1;
            break;
         end
      end
      check("timer.reach_ff", 32'(found), 32'd1);
      accept(t);
      wait_load(0, 8'h10, 1);
      check_fields("timer_ff", m_cnt, 8'hFF, 8'h10, 2'b01);
      finish_out(0, m_cnt, 8'hFF, 8'h10, 2'b01);
      m_cnt = m_cnt + 8'h01;
      accept(t);
      wait_load(0, 8'h11, 1);
      check_fields("timer_wrap", m_cnt, 8'h03, 8'h11, 2'b01);
      finish_out(0, m_cnt, 8'h03, 8'h11, 2'b01);
      m_cnt = m_cnt + 8'h01;

      // 256 back-to-back frames from reset: counter 01..FF then 01.
      do_reset();
      for (int i = 0; i < 256; i++) begin
         tg = 8'(i * 37 + 5);
         frame(0, tg, 0, (tg == 8'h00) ? 8'hFF : tg, (m_cnt == 8'hFF) ? 2'b11 : 2'b01);
      end
      check("seq.final_cnt", 32'(m_cnt), 32'h02);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
